// File: rtl/scm_pkg.sv
// Shared types and helpers for the multi-read-port standard-cell memory.
//   scm_state_e : clear-sequencer states
//   scm_clog2   : ceiling log2, used for array index / sweep counter width
//   scm_nb      : byte-lane count for a given data width
package scm_pkg;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_CLEAR = 1'b1
   } scm_state_e;

   function automatic int scm_clog2(input int value);
      int res;
      res = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         res++;
      end
      return res;
   endfunction

   function automatic int scm_nb(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/scm_rd_port.sv
// One read port of scm_mp: range check, array mux, write bypass merge,
// 1- or 2-stage output pipeline and RVALID pulse generation.
// Ports:
//   clk, rst      clock, async active-high reset
//   busy          clear sweep in progress; reads are dropped, outputs hold
//   re, raddr     read request and address for this port
//   we, waddr,    write port of the same cycle, used for the bypass merge
//   wbe, din
//   mem           storage array (current contents, before this edge's write)
//   dout, rvalid  registered read data and 1-cycle valid pulse
module scm_rd_port
   import scm_pkg::*;
#(
   parameter int DW       = 32,
   parameter int DEPTH    = 65,
   parameter int AW       = 7,
   parameter int READ_LAT = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              busy,
   input  logic              re,
   input  logic [AW-1:0]     raddr,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DW/8-1:0]   wbe,
   input  logic [DW-1:0]     din,
   input  logic [DW-1:0]     mem [DEPTH],
   output logic [DW-1:0]     dout,
   output logic              rvalid
);

   localparam int          NB      = scm_nb(DW);
   localparam int          IW      = (scm_clog2(DEPTH) > 0) ? scm_clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic          in_range;
   logic          hit;
   logic          acc;
   logic [DW-1:0] rd_data;
   logic [DW-1:0] dout_q, dout_d;
   logic          rvalid_q, rvalid_d;

   // Out-of-range addresses read as zero; the array is never indexed with them.
   always_comb begin
      in_range = ({1'b0, raddr} < DEPTH_W);
      acc      = re && !busy;
      hit      = (BYPASS != 0) && we && (waddr == raddr) && in_range;
      rd_data  = '0;
      if (in_range) begin
         rd_data = mem[raddr[IW-1:0]];
      end
      if (hit) begin
         for (int i = 0; i < NB; i++) begin
            if (wbe[i]) begin
               rd_data[8*i +: 8] = din[8*i +: 8];
            end
         end
      end
   end

   if (READ_LAT == 2) begin : g_lat2
      logic [DW-1:0] s1_data_q, s1_data_d;
      logic          s1_vld_q, s1_vld_d;

      // A result still in stage 1 when a sweep starts is discarded.
      always_comb begin
         s1_vld_d  = acc;
         s1_data_d = acc ? rd_data : s1_data_q;
         rvalid_d  = s1_vld_q && !busy;
         dout_d    = (s1_vld_q && !busy) ? s1_data_q : dout_q;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s1_data_q <= '0;
            s1_vld_q  <= 1'b0;
         end else begin
            s1_data_q <= s1_data_d;
            s1_vld_q  <= s1_vld_d;
         end
      end
   end else begin : g_lat1
      always_comb begin
         rvalid_d = acc;
         dout_d   = acc ? rd_data : dout_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q   <= '0;
         rvalid_q <= 1'b0;
      end else begin
         dout_q   <= dout_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign dout   = dout_q;
   assign rvalid = rvalid_q;

endmodule

// File: rtl/scm_mp.sv
// Parametrised standard-cell memory: one byte-enabled write port, NRD
// independent read ports, selectable read latency, optional same-address
// write-to-read bypass, and a sequencer that zeroes the array after reset
// and on request.
// Ports:
//   clk, rst   clock, async active-high reset
//   CLR        start a clear sweep (only looked at when idle)
//   BUSY       sweep in progress; reads and writes are ignored
//   WE, WADDR, WBE, DIN   write port, WBE[i] enables DIN[8i+7:8i]
//   RE, RADDR  per-port read enables, port p address at [p*AW +: AW]
//   DOUT       per-port read data at [p*DW +: DW]
//   RVALID     per-port 1-cycle valid pulse
//
// Clear sequencer states:
//   state   | meaning
//   S_IDLE  | normal access, waiting for CLR
//   S_CLEAR | writing 0 to entry ctr, one per cycle, BUSY=1
module scm_mp
   import scm_pkg::*;
#(
   parameter int DW       = 32,
   parameter int DEPTH    = 65,
   parameter int AW       = 7,
   parameter int NRD      = 2,
   parameter int READ_LAT = 1,
   parameter int BYPASS   = 1,
   parameter int INIT_CLR = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                CLR,
   output logic                BUSY,
   input  logic                WE,
   input  logic [AW-1:0]       WADDR,
   input  logic [DW/8-1:0]     WBE,
   input  logic [DW-1:0]       DIN,
   input  logic [NRD-1:0]      RE,
   input  logic [NRD*AW-1:0]   RADDR,
   output logic [NRD*DW-1:0]   DOUT,
   output logic [NRD-1:0]      RVALID
);

   localparam int          NB       = scm_nb(DW);
   localparam int          IW       = (scm_clog2(DEPTH) > 0) ? scm_clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_W  = (AW+1)'(DEPTH);
   localparam logic [IW-1:0] CTR_LAST = IW'(DEPTH - 1);

   scm_state_e    state_q, state_d;
   logic [IW-1:0] ctr_q, ctr_d;
   logic          busy_q, busy_d;

   logic [DW-1:0] mem_q [DEPTH];
   logic          wr_en;
   logic [DW-1:0] wr_row;

   always_comb begin
      state_d = state_q;
      ctr_d   = ctr_q;
      busy_d  = busy_q;
      case (state_q)
         S_IDLE: begin
            if (CLR) begin
               state_d = S_CLEAR;
               ctr_d   = '0;
               busy_d  = 1'b1;
            end
         end
         S_CLEAR: begin
            if (ctr_q == CTR_LAST) begin
               state_d = S_IDLE;
               ctr_d   = '0;
               busy_d  = 1'b0;
            end else begin
               ctr_d = ctr_q + IW'(1);
            end
         end
         default: begin
            state_d = S_IDLE;
            ctr_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= (INIT_CLR != 0) ? S_CLEAR : S_IDLE;
         ctr_q   <= '0;
         busy_q  <= (INIT_CLR != 0);
      end else begin
         state_q <= state_d;
         ctr_q   <= ctr_d;
         busy_q  <= busy_d;
      end
   end

   assign BUSY = busy_q;

   // Read-modify-write of the addressed row so unselected lanes keep old data.
   always_comb begin
      wr_en  = WE && !busy_q && ({1'b0, WADDR} < DEPTH_W);
      wr_row = '0;
      if (wr_en) begin
         wr_row = mem_q[WADDR[IW-1:0]];
         for (int i = 0; i < NB; i++) begin
            if (WBE[i]) begin
               wr_row[8*i +: 8] = DIN[8*i +: 8];
            end
         end
      end
   end

   // Array cells have no reset; only the sweep initialises them.
   always_ff @(posedge clk) begin
      if (busy_q) begin
         mem_q[ctr_q] <= '0;
      end else if (wr_en) begin
         mem_q[WADDR[IW-1:0]] <= wr_row;
      end
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      scm_rd_port #(
         .DW       (DW),
         .DEPTH    (DEPTH),
         .AW       (AW),
         .READ_LAT (READ_LAT),
         .BYPASS   (BYPASS)
      ) u_rd (
         .clk    (clk),
         .rst    (rst),
         .busy   (busy_q),
         .re     (RE[p]),
         .raddr  (RADDR[p*AW +: AW]),
         .we     (WE),
         .waddr  (WADDR),
         .wbe    (WBE),
         .din    (DIN),
         .mem    (mem_q),
         .dout   (DOUT[p*DW +: DW]),
         .rvalid (RVALID[p])
      );
   end

endmodule

// File: tb/tb_scm_mp.sv
// Directed bench for scm_mp. Two instances share all inputs:
//   u_dut_a : READ_LAT=1, BYPASS=1
//   u_dut_b : READ_LAT=2, BYPASS=0
module tb_scm_mp;

   logic        clk = 1'b0;
   logic        rst;
   logic        CLR;
   logic        WE;
   logic [6:0]  WADDR;
   logic [3:0]  WBE;
   logic [31:0] DIN;
   logic [1:0]  RE;
   logic [13:0] RADDR;

   logic        BUSY_a, BUSY_b;
   logic [63:0] DOUT_a, DOUT_b;
   logic [1:0]  RVALID_a, RVALID_b;

   int checks = 0;
   int errors = 0;
   int n;
   logic rv_seen;

   always #5 clk = ~clk;

   scm_mp #(.DW(32), .DEPTH(65), .AW(7), .NRD(2), .READ_LAT(1), .BYPASS(1), .INIT_CLR(1)) u_dut_a (
      .clk(clk), .rst(rst), .CLR(CLR), .BUSY(BUSY_a), .WE(WE), .WADDR(WADDR), .WBE(WBE),
      .DIN(DIN), .RE(RE), .RADDR(RADDR), .DOUT(DOUT_a), .RVALID(RVALID_a));

   scm_mp #(.DW(32), .DEPTH(65), .AW(7), .NRD(2), .READ_LAT(2), .BYPASS(0), .INIT_CLR(1)) u_dut_b (
      .clk(clk), .rst(rst), .CLR(CLR), .BUSY(BUSY_b), .WE(WE), .WADDR(WADDR), .WBE(WBE),
      .DIN(DIN), .RE(RE), .RADDR(RADDR), .DOUT(DOUT_b), .RVALID(RVALID_b));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [6:0] a, input logic [3:0] be, input logic [31:0] d);
      WE = 1'b1; WADDR = a; WBE = be; DIN = d;
      tick();
      WE = 1'b0;
   endtask

   // Both ports read (optionally with a write on the same edge); checks the
   // 1-cycle instance, then the 2-cycle instance, then output hold.
   task automatic cyc(input logic we, input logic [6:0] wa, input logic [3:0] be,
                      input logic [31:0] d, input logic [6:0] a0, input logic [6:0] a1,
                      input logic [31:0] ea0, input logic [31:0] ea1,
                      input logic [31:0] eb0, input logic [31:0] eb1, input string tag);
      WE = we; WADDR = wa; WBE = be; DIN = d;
      RE = 2'b11; RADDR = {a1, a0};
      tick();
      WE = 1'b0; RE = 2'b00;
      chk({tag, " A.rvalid"}, {30'd0, RVALID_a}, 32'd3);
      chk({tag, " A.dout0"}, DOUT_a[31:0], ea0);
      chk({tag, " A.dout1"}, DOUT_a[63:32], ea1);
      chk({tag, " B.rvalid early"}, {30'd0, RVALID_b}, 32'd0);
      tick();
      chk({tag, " B.rvalid"}, {30'd0, RVALID_b}, 32'd3);
      chk({tag, " B.dout0"}, DOUT_b[31:0], eb0);
      chk({tag, " B.dout1"}, DOUT_b[63:32], eb1);
      chk({tag, " A.rvalid pulse"}, {30'd0, RVALID_a}, 32'd0);
      chk({tag, " A.dout0 hold"}, DOUT_a[31:0], ea0);
      tick();
      chk({tag, " B.rvalid pulse"}, {30'd0, RVALID_b}, 32'd0);
      chk({tag, " B.dout0 hold"}, DOUT_b[31:0], eb0);
   endtask

   initial begin
      rst = 1'b1; CLR = 1'b0; WE = 1'b0; WADDR = '0; WBE = '0; DIN = '0; RE = '0; RADDR = '0;
      tick();
      tick();
      chk("rst A.busy", {31'd0, BUSY_a}, 32'd1);
      chk("rst B.busy", {31'd0, BUSY_b}, 32'd1);
      chk("rst A.rvalid", {30'd0, RVALID_a}, 32'd0);
      chk("rst B.rvalid", {30'd0, RVALID_b}, 32'd0);
      chk("rst A.dout0", DOUT_a[31:0], 32'd0);
      chk("rst B.dout1", DOUT_b[63:32], 32'd0);

      // initial sweep length
      rst = 1'b0;
      n = 0;
      while (BUSY_a && n < 200) begin
         n++;
         tick();
      end
      chk("init sweep cycles", n, 32'd65);
      chk("init B.busy done", {31'd0, BUSY_b}, 32'd0);

      for (int a = 0; a < 65; a++) begin
         cyc(1'b0, 7'd0, 4'h0, 32'd0, 7'(a), 7'(64 - a), 32'd0, 32'd0, 32'd0, 32'd0, "clr rd");
      end

      // byte-lane writes
      wr(7'd5, 4'hF, 32'h11223344);
      wr(7'd5, 4'b0101, 32'hAABBCCDD);
      cyc(1'b0, 7'd0, 4'h0, 32'd0, 7'd5, 7'd5,
          32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, "wbe");
      wr(7'd5, 4'h0, 32'hFFFFFFFF);
      cyc(1'b0, 7'd0, 4'h0, 32'd0, 7'd5, 7'd4,
          32'h11BB33DD, 32'd0, 32'h11BB33DD, 32'd0, "wbe0 noop");

      // collisions: A bypasses, B returns old data
      cyc(1'b1, 7'd9, 4'hF, 32'hDEADBEEF, 7'd9, 7'd9,
          32'hDEADBEEF, 32'hDEADBEEF, 32'd0, 32'd0, "coll full");
      cyc(1'b1, 7'd9, 4'b0011, 32'h12345678, 7'd9, 7'd9,
          32'hDEAD5678, 32'hDEAD5678, 32'hDEADBEEF, 32'hDEADBEEF, "coll lane");
      cyc(1'b0, 7'd0, 4'h0, 32'd0, 7'd9, 7'd9,
          32'hDEAD5678, 32'hDEAD5678, 32'hDEAD5678, 32'hDEAD5678, "coll after");

      // first/last entries on both ports at once
      wr(7'd3, 4'hF, 32'h0A0B0C0D);
      wr(7'd64, 4'hF, 32'hCAFEF00D);
      cyc(1'b0, 7'd0, 4'h0, 32'd0, 7'd3, 7'd64,
          32'h0A0B0C0D, 32'hCAFEF00D, 32'h0A0B0C0D, 32'hCAFEF00D, "rd 3/64");

      // out-of-range accesses
      wr(7'd6, 4'hF, 32'h66666666);
      wr(7'd70, 4'hF, 32'h55555555);
      cyc(1'b0, 7'd0, 4'h0, 32'd0, 7'd70, 7'd6,
          32'd0, 32'h66666666, 32'd0, 32'h66666666, "oor 70/6");
      cyc(1'b0, 7'd0, 4'h0, 32'd0, 7'd127, 7'd64,
          32'd0, 32'hCAFEF00D, 32'd0, 32'hCAFEF00D, "oor 127/64");

      // clear request, then reset partway through the sweep
      wr(7'd30, 4'hF, 32'h30303030);
      cyc(1'b0, 7'd0, 4'h0, 32'd0, 7'd30, 7'd64,
          32'h30303030, 32'hCAFEF00D, 32'h30303030, 32'hCAFEF00D, "pre clr");
      CLR = 1'b1;
      tick();
      CLR = 1'b0;
      chk("clr A.busy", {31'd0, BUSY_a}, 32'd1);
      WE = 1'b1; WADDR = 7'd10; WBE = 4'hF; DIN = 32'hFFFFFFFF;
      RE = 2'b11; RADDR = {7'd64, 7'd30};
      rv_seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         rv_seen = rv_seen | (|RVALID_a) | (|RVALID_b);
      end
      chk("busy rvalid", {31'd0, rv_seen}, 32'd0);
      chk("busy A.dout0 hold", DOUT_a[31:0], 32'h30303030);
      chk("busy B.dout1 hold", DOUT_b[63:32], 32'hCAFEF00D);
      chk("mid A.busy", {31'd0, BUSY_a}, 32'd1);

      rst = 1'b1;
      #1;
      chk("mid rst A.dout0", DOUT_a[31:0], 32'd0);
      chk("mid rst A.dout1", DOUT_a[63:32], 32'd0);
      chk("mid rst B.dout0", DOUT_b[31:0], 32'd0);
      chk("mid rst B.dout1", DOUT_b[63:32], 32'd0);
      chk("mid rst A.busy", {31'd0, BUSY_a}, 32'd1);
      tick();
      tick();
      rst = 1'b0;
      CLR = 1'b1;
      n = 0;
      rv_seen = 1'b0;
      while (BUSY_a && n < 200) begin
         n++;
         tick();
         rv_seen = rv_seen | (|RVALID_a) | (|RVALID_b);
      end
      WE = 1'b0; RE = 2'b00; CLR = 1'b0;
      chk("restart sweep cycles", n, 32'd65);
      chk("restart rvalid", {31'd0, rv_seen}, 32'd0);
      chk("restart A.dout0 hold", DOUT_a[31:0], 32'd0);
      chk("restart B.busy", {31'd0, BUSY_b}, 32'd0);

      cyc(1'b0, 7'd0, 4'h0, 32'd0, 7'd10, 7'd30, 32'd0, 32'd0, 32'd0, 32'd0, "post 10/30");
      cyc(1'b0, 7'd0, 4'h0, 32'd0, 7'd64, 7'd5, 32'd0, 32'd0, 32'd0, 32'd0, "post 64/5");
      cyc(1'b0, 7'd0, 4'h0, 32'd0, 7'd9, 7'd3, 32'd0, 32'd0, 32'd0, 32'd0, "post 9/3");
      chk("post idle A.busy", {31'd0, BUSY_a}, 32'd0);

      wr(7'd10, 4'hF, 32'h12345678);
      cyc(1'b0, 7'd0, 4'h0, 32'd0, 7'd10, 7'd10,
          32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, "post wr");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
